ahb_ext_mem_bridge: RTL and testbench
=====================================

// Module: ahb_ext_mem_bridge
// PURPOSE
//  AHB-Lite subordinate on the SoC external-memory port. It consumes the HSELEXT-qualified bus
//  outputs and returns HRDATAEXT/HREADYEXT/HRESPEXT. Each transfer becomes one valid/ready
//  request to an off-chip memory agent, with wait states, size/alignment checks and a timeout.
//  One transfer is outstanding at a time.
// PARAMETERS
//  PA_BITS   56   physical address width (matches P.PA_BITS)
//  AHBW      64   bus data width in bits, 32 or 64 (matches P.AHBW)
//  TIMEOUT   255  cycles from data-phase start to error completion; 0 disables the timeout
// PORTS
//  HCLK            in   1        bus clock; everything is on the rising edge
//  HRESETn         in   1        asynchronous active-low reset
//  HSELEXT         in   1        external region select
//  HADDR           in   PA_BITS  address-phase address
//  HWRITE          in   1        address-phase direction
//  HSIZE           in   3        address-phase size
//  HTRANS          in   2        address-phase transfer type
//  HREADY          in   1        bus-wide ready; the address phase is sampled only when it is 1
//  HWDATA          in   AHBW     data-phase write data
//  HWSTRB          in   AHBW/8   data-phase byte strobes
//  HRDATAEXT       out  AHBW     read data
//  HREADYEXT       out  1        subordinate ready
//  HRESPEXT        out  1        1 = ERROR
//  mem_req_valid   out  1        request valid
//  mem_req_ready   in   1        request accepted
//  mem_req_write   out  1        request is a write
//  mem_req_addr    out  PA_BITS  request address
//  mem_req_wdata   out  AHBW     request write data
//  mem_req_wstrb   out  AHBW/8   request byte strobes
//  mem_rsp_valid   in   1        response valid, single-cycle pulse
//  mem_rsp_rdata   in   AHBW     response read data
//  mem_rsp_err     in   1        response error
// BEHAVIOUR
//  - Reset values: HREADYEXT=1, HRESPEXT=0, HRDATAEXT=0, mem_req_valid=0, stale=0, state=IDLE.
//    All outputs are registered.
//  - Transfer capture: HSELEXT & HREADY & HTRANS[1] (NONSEQ or SEQ). Latch HADDR, HWRITE, HSIZE.
//  - IDLE/BUSY with HSELEXT: OKAY with zero wait states; no state change.
//  - Captured transfer with HSIZE > log2(AHBW/8), or HADDR not aligned to the size: go to ERR1.
//    No memory request is issued.
//  - Otherwise go to REQ and set HREADYEXT=0 in the first data-phase cycle.
//  - REQ: mem_req_valid=1; wdata/wstrb taken directly from HWDATA/HWSTRB (stable during wait
//    states); read requests drive wstrb=0. Valid is held until mem_req_ready. On accept, go to
//    WAIT_RSP.
//  - WAIT_RSP, mem_rsp_valid & !mem_rsp_err: next cycle HRDATAEXT=mem_rsp_rdata (reads only;
//    otherwise hold), HREADYEXT=1, HRESPEXT=0, go to DONE. The cycle after acceptance is the
//    earliest response.
//  - WAIT_RSP, mem_rsp_valid & mem_rsp_err: go to ERR1.
//  - DONE and ERR2 are completion cycles, so the bus HREADY is 1. A transfer captured in that
//    cycle goes straight to REQ or ERR1 (back-to-back, no bubble); otherwise go to IDLE.
//  - ERR1: HRESPEXT=1, HREADYEXT=0. ERR2: HRESPEXT=1, HREADYEXT=1. This is the AHB two-cycle
//    error response.
//  - Timeout: a counter clears when the state enters REQ and increments in REQ and WAIT_RSP.
//    When count==TIMEOUT, go to ERR1.
//  - Timeout in REQ: mem_req_valid drops. This is the only permitted drop of valid before ready.
//  - Timeout in WAIT_RSP: set stale. The next mem_rsp_valid is discarded and clears stale.
//  - Timeout and response in the same cycle: the response wins.
//  - mem_rsp_valid outside WAIT_RSP with stale=0 is a protocol error: ignored, with a simulation
//    assertion.
//  - Asserting HRESETn mid-transfer returns immediately to the reset values; the in-flight
//    request is abandoned.
//  - Addresses pass through unmodified (PA_BITS). There is no address translation or
//    region-base subtraction.
// STRUCTURE
//  - Shared package (cvw): htrans_t constants (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10,
//    SEQ=2'b11); ext_bridge_state_t enum {IDLE, REQ, WAIT_RSP, DONE, ERR1, ERR2}.
//  - One sub-module: ext_bridge_timeout (counter, clear/enable, terminal-count flag,
//    width $clog2(TIMEOUT+1)).
//  - The rest is one FSM plus an address/control capture register in this file.
// TESTING
//  1. 64-bit read, HADDR=0x8000_0000, HSIZE=3; agent ready=1, rsp 2 cycles later with
//     rdata=0xDEADBEEF_CAFEF00D -> HREADYEXT low 3 cycles, then data with OKAY.
//  2. Byte write, HADDR=0x8000_0003, HSIZE=0, HWSTRB=8'h08 -> req write=1,
//     addr=0x8000_0003, wstrb=8'h08; completes OKAY.
//  3. HSIZE=1 at HADDR=0x8000_0001 -> no mem_req_valid; ERR1 (HRESP=1, HREADY=0), then
//     ERR2 (HRESP=1, HREADY=1).
//  4. TIMEOUT=8, agent never responds -> error response 8 cycles into the data phase.
//     A late rsp_valid is discarded. The next read then completes with its own data.
//  5. Two NONSEQ reads back-to-back, agent responds immediately -> second address is
//     captured in the DONE cycle; no idle bubble; both sets of data are correct.
//  6. Drop HRESETn while in WAIT_RSP -> next edge: HREADYEXT=1, mem_req_valid=0, state=IDLE.

Source files
------------

// File: rtl/ahb_ext_mem_bridge_pkg.sv
// ---------------------------------------------------------------------------
// ahb_ext_mem_bridge_pkg
//   Shared types and helpers for the AHB-Lite external-memory bridge.
//   - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   - ext_bridge_state_t: bridge FSM states
//   - xfer_bad(): size / alignment legality check for a captured transfer
// ---------------------------------------------------------------------------
package ahb_ext_mem_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_RSP = 3'd2,
    DONE     = 3'd3,
    ERR1     = 3'd4,
    ERR2     = 3'd5
  } ext_bridge_state_t;

  // A transfer is illegal when it is wider than the bus or when the address
  // is not a multiple of the transfer size. Only the low three address bits
  // matter for buses of up to 64 bits.
  function automatic logic xfer_bad(input logic [2:0] size,
                                    input logic [2:0] max_size,
                                    input logic [2:0] addr_lo);
    logic [2:0] mask;
    case (size)
      3'd0:    mask = 3'b000;
      3'd1:    mask = 3'b001;
      3'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    xfer_bad = (size > max_size) || ((addr_lo & mask) != 3'b000);
  endfunction

endpackage

// File: rtl/ahb_ext_mem_bridge_timeout.sv
// ---------------------------------------------------------------------------
// ext_bridge_timeout
//   Data-phase timeout counter for the external-memory bridge.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : clear the count (takes priority over en)
//     en         : count this cycle
//     hit        : terminal count; asserted in the cycle whose increment
//                  brings the count to TIMEOUT. TIMEOUT=0 never hits.
// ---------------------------------------------------------------------------
module ext_bridge_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // With the count cleared on entry to REQ, the bridge leaves the data phase
  // for ERR1 after exactly TIMEOUT waiting cycles.
  assign hit = (TIMEOUT != 0) && en && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/ahb_ext_mem_bridge.sv
// ---------------------------------------------------------------------------
// ahb_ext_mem_bridge
//   AHB-Lite subordinate for the SoC external-memory region. Each legal
//   NONSEQ/SEQ transfer becomes one valid/ready request to an off-chip memory
//   agent; one transfer is outstanding at a time.
//   Ports:
//     HCLK, HRESETn       : clock, asynchronous active-low reset
//     HSELEXT..HWSTRB     : AHB-Lite bus inputs (address + data phase)
//     HRDATAEXT/HREADYEXT/HRESPEXT : registered subordinate response
//     mem_req_*           : request channel to the memory agent
//     mem_rsp_*           : single-cycle response pulse from the agent
//     state_dbg           : current FSM state (ext_bridge_state_t encoding)
//
//   Handshake: a request transfers on a rising edge where mem_req_valid and
//   mem_req_ready are both 1. Once raised, valid and the request fields stay
//   stable until that edge; the only exception is a timeout in REQ, which
//   withdraws valid. mem_rsp_valid is a one-cycle pulse with no back-pressure.
// ---------------------------------------------------------------------------
module ahb_ext_mem_bridge #(
  parameter int PA_BITS = 56,
  parameter int AHBW    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSELEXT,
  input  logic [PA_BITS-1:0]   HADDR,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [1:0]           HTRANS,
  input  logic                 HREADY,
  input  logic [AHBW-1:0]      HWDATA,
  input  logic [AHBW/8-1:0]    HWSTRB,
  output logic [AHBW-1:0]      HRDATAEXT,
  output logic                 HREADYEXT,
  output logic                 HRESPEXT,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_write,
  output logic [PA_BITS-1:0]   mem_req_addr,
  output logic [AHBW-1:0]      mem_req_wdata,
  output logic [AHBW/8-1:0]    mem_req_wstrb,
  input  logic                 mem_rsp_valid,
  input  logic [AHBW-1:0]      mem_rsp_rdata,
  input  logic                 mem_rsp_err,
  output logic [2:0]           state_dbg
);

  import ahb_ext_mem_bridge_pkg::*;

  localparam logic [2:0] MAX_SIZE = 3'($clog2(AHBW / 8));

  ext_bridge_state_t   state;
  logic [PA_BITS-1:0]  addr_q;
  logic                write_q;
  logic                stale;

  logic                capture;
  logic                cap_bad;
  logic                can_capture;
  logic                tmo_clr;
  logic                tmo_en;
  logic                tmo_hit;

  assign capture     = HSELEXT && HREADY &&
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  // The size only feeds the legality check, so it is not kept past capture.
  assign cap_bad     = xfer_bad(HSIZE, MAX_SIZE, HADDR[2:0]);
  // IDLE, DONE and ERR2 are the cycles in which HREADYEXT is 1.
  assign can_capture = (state == IDLE) || (state == DONE) || (state == ERR2);
  assign tmo_clr     = can_capture && capture && !cap_bad;
  assign tmo_en      = (state == REQ) || (state == WAIT_RSP);

  ext_bridge_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .hit   (tmo_hit)
  );

  // Write data and strobes are stable on HWDATA/HWSTRB throughout the wait
  // states, so they go straight to the agent instead of through a register.
  assign mem_req_addr  = addr_q;
  assign mem_req_write = write_q;
  assign mem_req_wdata = HWDATA;
  assign mem_req_wstrb = write_q ? HWSTRB : '0;
  assign state_dbg     = state;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state         <= IDLE;
      HREADYEXT     <= 1'b1;
      HRESPEXT      <= 1'b0;
      HRDATAEXT     <= '0;
      mem_req_valid <= 1'b0;
      stale         <= 1'b0;
      addr_q        <= '0;
      write_q       <= 1'b0;
    end else begin
      // A response belonging to an abandoned request is dropped wherever it
      // lands; WAIT_RSP handles its own case below.
      if (mem_rsp_valid && stale && (state != WAIT_RSP)) begin
        stale <= 1'b0;
      end

      case (state)
        IDLE, DONE, ERR2: begin
          if (capture) begin
            addr_q    <= HADDR;
            write_q   <= HWRITE;
            HREADYEXT <= 1'b0;
            if (cap_bad) begin
              state    <= ERR1;
              HRESPEXT <= 1'b1;
            end else begin
              state         <= REQ;
              HRESPEXT      <= 1'b0;
              mem_req_valid <= 1'b1;
            end
          end else begin
            state     <= IDLE;
            HREADYEXT <= 1'b1;
            HRESPEXT  <= 1'b0;
          end
        end

        REQ: begin
          if (tmo_hit) begin
            state         <= ERR1;
            HRESPEXT      <= 1'b1;
            mem_req_valid <= 1'b0;
            // Accepted on the very edge it timed out: its response is owed.
            if (mem_req_ready) begin
              stale <= 1'b1;
            end
          end else if (mem_req_ready) begin
            state         <= WAIT_RSP;
            mem_req_valid <= 1'b0;
          end
        end

        WAIT_RSP: begin
          // A live response beats a timeout in the same cycle.
          if (mem_rsp_valid && !stale) begin
            if (mem_rsp_err) begin
              state    <= ERR1;
              HRESPEXT <= 1'b1;
            end else begin
              state     <= DONE;
              HREADYEXT <= 1'b1;
              HRESPEXT  <= 1'b0;
              if (!write_q) begin
                HRDATAEXT <= mem_rsp_rdata;
              end
            end
          end else if (tmo_hit) begin
            state    <= ERR1;
            HRESPEXT <= 1'b1;
            stale    <= 1'b1;
          end else if (mem_rsp_valid) begin
            stale <= 1'b0;
          end
        end

        ERR1: begin
          state     <= ERR2;
          HREADYEXT <= 1'b1;
          HRESPEXT  <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          HREADYEXT <= 1'b1;
          HRESPEXT  <= 1'b0;
        end
      endcase
    end
  end

  // The agent may only respond to the outstanding request or to one that
  // was abandoned by a timeout.
  a_rsp_expected: assert property (@(posedge HCLK) disable iff (!HRESETn)
    mem_rsp_valid |-> ((state == WAIT_RSP) || stale));

endmodule

// File: tb/tb_ahb_ext_mem_bridge.sv
module tb_ahb_ext_mem_bridge;

  localparam int PA_BITS = 56;
  localparam int AHBW    = 64;
  localparam int TIMEOUT = 8;

  logic                HCLK = 1'b0;
  logic                HRESETn;
  logic                HSELEXT;
  logic [PA_BITS-1:0]  HADDR;
  logic                HWRITE;
  logic [2:0]          HSIZE;
  logic [1:0]          HTRANS;
  logic                HREADY;
  logic [AHBW-1:0]     HWDATA;
  logic [AHBW/8-1:0]   HWSTRB;
  logic [AHBW-1:0]     HRDATAEXT;
  logic                HREADYEXT;
  logic                HRESPEXT;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_write;
  logic [PA_BITS-1:0]  mem_req_addr;
  logic [AHBW-1:0]     mem_req_wdata;
  logic [AHBW/8-1:0]   mem_req_wstrb;
  logic                mem_rsp_valid;
  logic [AHBW-1:0]     mem_rsp_rdata;
  logic                mem_rsp_err;
  logic [2:0]          state_dbg;

  // Single-subordinate interconnect: bus ready is the bridge's ready.
  assign HREADY = HREADYEXT;

  ahb_ext_mem_bridge #(.PA_BITS(PA_BITS), .AHBW(AHBW), .TIMEOUT(TIMEOUT)) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .HSELEXT       (HSELEXT),
    .HADDR         (HADDR),
    .HWRITE        (HWRITE),
    .HSIZE         (HSIZE),
    .HTRANS        (HTRANS),
    .HREADY        (HREADY),
    .HWDATA        (HWDATA),
    .HWSTRB        (HWSTRB),
    .HRDATAEXT     (HRDATAEXT),
    .HREADYEXT     (HREADYEXT),
    .HRESPEXT      (HRESPEXT),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_write (mem_req_write),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_err   (mem_rsp_err),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [AHBW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- memory agent ----------------
  int              agent_ready_dly = 0;
  int              agent_rsp_dly   = 1;
  logic            agent_err       = 1'b0;
  logic            agent_respond   = 1'b1;
  logic            agent_junk      = 1'b0;
  logic [AHBW-1:0] agent_rdata_q[$];

  int              req_seen = 0;
  logic            last_write;
  logic [PA_BITS-1:0] last_addr;
  logic [AHBW-1:0] last_wdata;
  logic [AHBW/8-1:0] last_wstrb;

  int              hold_cnt = 0;
  int              rsp_cnt  = 0;
  int              junk_cnt = 0;
  logic            cur_respond = 1'b0;
  logic            cur_err     = 1'b0;
  logic [AHBW-1:0] cur_rdata   = '0;

  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    mem_rsp_err   = 1'b0;
    forever begin
      @(negedge HCLK);
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      if (junk_cnt > 0) begin
        junk_cnt--;
        if (junk_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        end
      end
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0 && cur_respond) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = cur_rdata;
          mem_rsp_err   = cur_err;
        end
      end
      if (mem_req_valid) begin
        mem_req_ready = (hold_cnt >= agent_ready_dly);
        if (!mem_req_ready) hold_cnt++;
      end else begin
        hold_cnt      = 0;
        mem_req_ready = 1'b0;
      end
      if (mem_req_valid && mem_req_ready) begin
        req_seen++;
        last_write  = mem_req_write;
        last_addr   = mem_req_addr;
        last_wdata  = mem_req_wdata;
        last_wstrb  = mem_req_wstrb;
        cur_rdata   = (agent_rdata_q.size() > 0) ? agent_rdata_q.pop_front() : '0;
        cur_respond = agent_respond;
        cur_err     = agent_err;
        rsp_cnt     = agent_rsp_dly;
        junk_cnt    = agent_junk ? 1 : 0;
        hold_cnt    = 0;
      end
    end
  end

  // ---------------- bus driver ----------------
  task automatic bus_idle();
    HSELEXT = 1'b0;
    HTRANS  = 2'b00;
  endtask

  // One non-pipelined transfer; returns at the negedge of its completion cycle.
  task automatic run_xfer(input logic wr, input logic [PA_BITS-1:0] a, input logic [2:0] sz,
                          input logic [AHBW-1:0] wd, input logic [AHBW/8-1:0] ws,
                          output int waits, output logic err, output logic [AHBW-1:0] hrd,
                          output logic low_resp, output logic low_valid);
    @(negedge HCLK);
    HSELEXT = 1'b1;
    HTRANS  = 2'b10;
    HADDR   = a;
    HWRITE  = wr;
    HSIZE   = sz;
    HWDATA  = wd;
    HWSTRB  = ws;
    @(negedge HCLK);
    bus_idle();
    waits     = 0;
    low_resp  = 1'b0;
    low_valid = 1'b0;
    while (HREADYEXT == 1'b0 && waits < 60) begin
      waits++;
      low_resp  = HRESPEXT;
      low_valid = mem_req_valid;
      @(negedge HCLK);
    end
    err = HRESPEXT;
    hrd = HRDATAEXT;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              write;
    logic [PA_BITS-1:0] addr;
    logic [2:0]        size;
    logic [AHBW-1:0]   wdata;
    logic [AHBW/8-1:0] wstrb;
    logic [AHBW-1:0]   rdata;
    logic              rsp_err;
    int                ready_dly;
    int                rsp_dly;
    logic              exp_req;
    logic [AHBW/8-1:0] exp_wstrb;
    int                exp_waits;
    logic              exp_err;
    logic [AHBW-1:0]   exp_hrdata;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [PA_BITS-1:0] a, input logic [2:0] sz,
                              input logic [AHBW-1:0] wd, input logic [AHBW/8-1:0] ws,
                              input logic [AHBW-1:0] rd, input logic re, input int rdly,
                              input int sdly, input logic ereq, input logic [AHBW/8-1:0] ews,
                              input int ew, input logic ee, input logic [AHBW-1:0] eh);
    vec_t v;
    v.write = wr; v.addr = a; v.size = sz; v.wdata = wd; v.wstrb = ws;
    v.rdata = rd; v.rsp_err = re; v.ready_dly = rdly; v.rsp_dly = sdly;
    v.exp_req = ereq; v.exp_wstrb = ews; v.exp_waits = ew; v.exp_err = ee; v.exp_hrdata = eh;
    return v;
  endfunction

  localparam int NV = 10;
  vec_t vecs[NV];

  // ---------------- test ----------------
  initial begin
    int              waits;
    int              wa;
    int              wb;
    int              seen0;
    logic            err;
    logic            low_resp;
    logic            low_valid;
    logic [AHBW-1:0] hrd;

    //       wr  addr                   sz  wdata                   wstrb  rdata                   re rdy rsp req ewstrb waits err hrdata
    vecs[0] = mk(0, 56'h0000_0000_8000_0000, 3, 64'h0,                 8'hFF, 64'hDEADBEEF_CAFEF00D, 0, 0,  2,  1, 8'h00, 3, 0, 64'hDEADBEEF_CAFEF00D);
    vecs[1] = mk(1, 56'h0000_0000_8000_0003, 0, 64'h11223344_55667788, 8'h08, 64'h0,                 0, 0,  1,  1, 8'h08, 2, 0, 64'hDEADBEEF_CAFEF00D);
    vecs[2] = mk(0, 56'h0000_0000_8000_0001, 1, 64'h0,                 8'h00, 64'h0,                 0, 0,  1,  0, 8'h00, 1, 1, 64'hDEADBEEF_CAFEF00D);
    vecs[3] = mk(0, 56'h0000_0000_8000_0000, 4, 64'h0,                 8'h00, 64'h0,                 0, 0,  1,  0, 8'h00, 1, 1, 64'hDEADBEEF_CAFEF00D);
    vecs[4] = mk(0, 56'h0000_0000_8000_0004, 2, 64'h0,                 8'hF0, 64'h01234567_89ABCDEF, 0, 2,  1,  1, 8'h00, 4, 0, 64'h01234567_89ABCDEF);
    vecs[5] = mk(0, 56'h0000_0000_8000_0008, 3, 64'h0,                 8'h00, 64'hFFFFFFFF_FFFFFFFF, 1, 0,  1,  1, 8'h00, 3, 1, 64'h01234567_89ABCDEF);
    vecs[6] = mk(1, 56'h0000_0000_8000_0006, 1, 64'hAABB0000_00000000, 8'hC0, 64'h0,                 0, 0,  3,  1, 8'hC0, 4, 0, 64'h01234567_89ABCDEF);
    vecs[7] = mk(1, 56'h0000_0000_8000_0004, 3, 64'h0,                 8'hFF, 64'h0,                 0, 0,  1,  0, 8'h00, 1, 1, 64'h01234567_89ABCDEF);
    vecs[8] = mk(0, 56'h0000_0000_8000_0010, 3, 64'h0,                 8'h00, 64'h0,                 0, 20, 1,  0, 8'h00, 9, 1, 64'h01234567_89ABCDEF);
    vecs[9] = mk(0, 56'hFF_FFFF_FFFF_FFF8,   3, 64'h0,                 8'h00, 64'hA5A55A5A_0F0FF0F0, 0, 0,  1,  1, 8'h00, 2, 0, 64'hA5A55A5A_0F0FF0F0);

    HRESETn = 1'b0;
    bus_idle();
    HADDR  = '0;
    HWRITE = 1'b0;
    HSIZE  = 3'd0;
    HWDATA = '0;
    HWSTRB = '0;
    repeat (3) @(negedge HCLK);

    chk("rst_hreadyext", 64'(HREADYEXT), 64'd1);
    chk("rst_hrespext", 64'(HRESPEXT), 64'd0);
    chk("rst_hrdataext", HRDATAEXT, 64'd0);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    HRESETn = 1'b1;

    // IDLE and BUSY while selected: zero-wait OKAY, no request.
    seen0 = req_seen;
    @(negedge HCLK);
    HSELEXT = 1'b1; HTRANS = 2'b00; HADDR = 56'h8000_0000;
    @(negedge HCLK);
    HTRANS = 2'b01;
    @(negedge HCLK);
    chk("idle_busy_hready", 64'(HREADYEXT), 64'd1);
    chk("idle_busy_hresp", 64'(HRESPEXT), 64'd0);
    chk("idle_busy_valid", 64'(mem_req_valid), 64'd0);
    @(negedge HCLK);
    bus_idle();
    chk("idle_busy_state", 64'(state_dbg), 64'd0);
    chk("idle_busy_noreq", 64'(req_seen - seen0), 64'd0);

    // Table-driven single transfers.
    for (int i = 0; i < NV; i++) begin
      agent_rdata_q.delete();
      agent_ready_dly = vecs[i].ready_dly;
      agent_rsp_dly   = vecs[i].rsp_dly;
      agent_err       = vecs[i].rsp_err;
      agent_respond   = 1'b1;
      agent_junk      = 1'b0;
      if (vecs[i].exp_req) agent_rdata_q.push_back(vecs[i].rdata);
      exp_q.push_back(vecs[i].exp_hrdata);
      seen0 = req_seen;
      run_xfer(vecs[i].write, vecs[i].addr, vecs[i].size, vecs[i].wdata, vecs[i].wstrb,
               waits, err, hrd, low_resp, low_valid);
      chk($sformatf("v%0d_waits", i), 64'(waits), 64'(vecs[i].exp_waits));
      chk($sformatf("v%0d_hresp", i), 64'(err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_err1_resp", i), 64'(low_resp), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_valid_last_low", i), 64'(low_valid), 64'd0);
      chk($sformatf("v%0d_hrdata", i), hrd, exp_q.pop_front());
      chk($sformatf("v%0d_req_count", i), 64'(req_seen - seen0), 64'(vecs[i].exp_req));
      if (vecs[i].exp_req) begin
        chk($sformatf("v%0d_req_write", i), 64'(last_write), 64'(vecs[i].write));
        chk($sformatf("v%0d_req_addr", i), 64'(last_addr), 64'(vecs[i].addr));
        chk($sformatf("v%0d_req_wstrb", i), 64'(last_wstrb), 64'(vecs[i].exp_wstrb));
        if (vecs[i].write) chk($sformatf("v%0d_req_wdata", i), last_wdata, vecs[i].wdata);
      end
    end

    // Timeout in WAIT_RSP, then a late response discarded inside the next transfer.
    agent_rdata_q.delete();
    agent_ready_dly = 0;
    agent_rsp_dly   = 1;
    agent_err       = 1'b0;
    agent_respond   = 1'b0;
    agent_rdata_q.push_back(64'h0);
    seen0 = req_seen;
    run_xfer(1'b0, 56'h8000_0020, 3'd3, 64'h0, 8'h00, waits, err, hrd, low_resp, low_valid);
    chk("tmo_wait_waits", 64'(waits), 64'd9);
    chk("tmo_wait_hresp", 64'(err), 64'd1);
    chk("tmo_wait_err1", 64'(low_resp), 64'd1);
    chk("tmo_wait_req", 64'(req_seen - seen0), 64'd1);

    agent_respond = 1'b1;
    agent_junk    = 1'b1;
    agent_rsp_dly = 3;
    agent_rdata_q.push_back(64'h13579BDF_2468ACE0);
    run_xfer(1'b0, 56'h8000_0028, 3'd3, 64'h0, 8'h00, waits, err, hrd, low_resp, low_valid);
    agent_junk = 1'b0;
    chk("stale_discard_waits", 64'(waits), 64'd4);
    chk("stale_discard_hresp", 64'(err), 64'd0);
    chk("stale_discard_data", hrd, 64'h13579BDF_2468ACE0);

    // Back-to-back reads: second address captured in the DONE cycle.
    agent_rdata_q.delete();
    agent_rsp_dly = 1;
    agent_rdata_q.push_back(64'h11111111_AAAAAAAA);
    agent_rdata_q.push_back(64'h22222222_BBBBBBBB);
    seen0 = req_seen;
    @(negedge HCLK);
    HSELEXT = 1'b1; HTRANS = 2'b10; HADDR = 56'h8000_0040; HWRITE = 1'b0; HSIZE = 3'd3;
    @(negedge HCLK);
    HTRANS = 2'b10; HADDR = 56'h8000_0048;
    wa = 0;
    while (HREADYEXT == 1'b0 && wa < 60) begin
      wa++;
      @(negedge HCLK);
    end
    chk("b2b_a_waits", 64'(wa), 64'd2);
    chk("b2b_a_data", HRDATAEXT, 64'h11111111_AAAAAAAA);
    chk("b2b_a_state_done", 64'(state_dbg), 64'd3);
    @(negedge HCLK);
    bus_idle();
    chk("b2b_b_no_bubble_valid", 64'(mem_req_valid), 64'd1);
    chk("b2b_b_no_bubble_hready", 64'(HREADYEXT), 64'd0);
    chk("b2b_b_req_addr", 64'(mem_req_addr), 64'h8000_0048);
    wb = 0;
    while (HREADYEXT == 1'b0 && wb < 60) begin
      wb++;
      @(negedge HCLK);
    end
    chk("b2b_b_waits", 64'(wb), 64'd2);
    chk("b2b_b_data", HRDATAEXT, 64'h22222222_BBBBBBBB);
    chk("b2b_b_hresp", 64'(HRESPEXT), 64'd0);
    chk("b2b_req_count", 64'(req_seen - seen0), 64'd2);

    // Reset while waiting for a response.
    agent_rdata_q.delete();
    agent_respond = 1'b0;
    agent_rdata_q.push_back(64'h0);
    @(negedge HCLK);
    HSELEXT = 1'b1; HTRANS = 2'b10; HADDR = 56'h8000_0080; HWRITE = 1'b0; HSIZE = 3'd3;
    @(negedge HCLK);
    bus_idle();
    chk("rstx_req_valid", 64'(mem_req_valid), 64'd1);
    @(negedge HCLK);
    chk("rstx_in_wait", 64'(state_dbg), 64'd2);
    HRESETn = 1'b0;
    @(posedge HCLK);
    #1;
    chk("rstx_hready", 64'(HREADYEXT), 64'd1);
    chk("rstx_valid", 64'(mem_req_valid), 64'd0);
    chk("rstx_state", 64'(state_dbg), 64'd0);
    chk("rstx_hresp", 64'(HRESPEXT), 64'd0);
    chk("rstx_hrdata", HRDATAEXT, 64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Recovery after reset.
    agent_rdata_q.delete();
    agent_respond = 1'b1;
    agent_rsp_dly = 2;
    agent_rdata_q.push_back(64'h0F1E2D3C_4B5A6978);
    run_xfer(1'b0, 56'h8000_0100, 3'd3, 64'h0, 8'h00, waits, err, hrd, low_resp, low_valid);
    chk("recover_waits", 64'(waits), 64'd3);
    chk("recover_hresp", 64'(err), 64'd0);
    chk("recover_data", hrd, 64'h0F1E2D3C_4B5A6978);

    repeat (2) @(negedge HCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
